// File: rtl/trdb_packet_parser.sv
// trdb_packet_parser
// Reassembles trace packets from a byte link: one length header byte
// (bits [5:0] = payload byte count N) followed by N payload bytes, LSB first.
// The packet is held on a valid/ready interface with its format fields decoded.
//
// Optional feature: define TRDB_PARSER_CHECKSUM_EN to expect one trailing
// checksum byte (XOR of header and payload bytes) after the payload.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   byte_valid_i/byte_i  incoming byte stream
//   byte_ready_o         parser accepts a byte this cycle
//   packet_valid_o       reassembled packet available
//   packet_ready_i       downstream consumes the packet
//   packet_payload_o     payload, byte 0 at [7:0], unreceived bytes zero
//   payload_length_o     payload byte count
//   format_o/subformat_o packet format fields
//   branches_o           branch count (format 1, else 0)
//   branch_map_o         branch map (format 1, else 0)
//   address_o            sign-extended address (format 2, else 0)
//   error_o              one-cycle pulse on a protocol error

module trdb_packet_parser #(
   parameter int unsigned MAX_BYTES        = 32,
   parameter int unsigned PAYLOAD_LEN      = 8 * MAX_BYTES,
   parameter int unsigned XLEN             = 32,
   parameter int unsigned BRANCH_COUNT_LEN = 5,
   parameter int unsigned BRANCH_MAP_LEN   = 31
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        byte_valid_i,
   input  logic [7:0]                  byte_i,
   output logic                        byte_ready_o,
   output logic                        packet_valid_o,
   input  logic                        packet_ready_i,
   output logic [PAYLOAD_LEN-1:0]      packet_payload_o,
   output logic [$clog2(MAX_BYTES):0]  payload_length_o,
   output logic [1:0]                  format_o,
   output logic [1:0]                  subformat_o,
   output logic [BRANCH_COUNT_LEN-1:0] branches_o,
   output logic [BRANCH_MAP_LEN-1:0]   branch_map_o,
   output logic [XLEN-1:0]             address_o,
   output logic                        error_o
);

   localparam int unsigned LEN_W = $clog2(MAX_BYTES) + 1;
   localparam int unsigned IDX_W = $clog2(PAYLOAD_LEN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
`ifdef TRDB_PARSER_CHECKSUM_EN
      S_CHECK,
`endif
      S_OUT
   } state_e;

   state_e                 state_q;
   logic [PAYLOAD_LEN-1:0] payload_q;
   logic [LEN_W-1:0]       len_q;
   logic [LEN_W-1:0]       cnt_q;
`ifdef TRDB_PARSER_CHECKSUM_EN
   logic [7:0]             chk_q;
`endif

   logic       accept;
   logic [5:0] hdr_len;
   logic       hdr_bad;
   logic       last_byte;

   assign accept    = byte_valid_i && byte_ready_o;
   assign hdr_len   = byte_i[5:0];
   assign hdr_bad   = (hdr_len == 6'd0) || (32'(hdr_len) > MAX_BYTES);
   assign last_byte = ((cnt_q + LEN_W'(1)) == len_q);

   // Packet FSM; all control outputs are registered alongside the state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= S_IDLE;
         payload_q      <= '0;
         len_q          <= '0;
         cnt_q          <= '0;
         byte_ready_o   <= 1'b1;
         packet_valid_o <= 1'b0;
         error_o        <= 1'b0;
`ifdef TRDB_PARSER_CHECKSUM_EN
         chk_q          <= '0;
`endif
      end else begin
         error_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (hdr_bad) begin
                     error_o <= 1'b1;
                  end else begin
                     payload_q <= '0;
                     len_q     <= LEN_W'(hdr_len);
                     cnt_q     <= '0;
                     state_q   <= S_COLLECT;
`ifdef TRDB_PARSER_CHECKSUM_EN
                     chk_q     <= byte_i;
`endif
                  end
               end
            end

            S_COLLECT: begin
               if (accept) begin
                  payload_q[IDX_W'({cnt_q, 3'b000}) +: 8] <= byte_i;
                  cnt_q <= cnt_q + LEN_W'(1);
`ifdef TRDB_PARSER_CHECKSUM_EN
                  chk_q <= chk_q ^ byte_i;
                  if (last_byte) begin
                     state_q <= S_CHECK;
                  end
`else
                  if (last_byte) begin
                     state_q        <= S_OUT;
                     byte_ready_o   <= 1'b0;
                     packet_valid_o <= 1'b1;
                  end
`endif
               end
            end

`ifdef TRDB_PARSER_CHECKSUM_EN
            // Trailing checksum byte: match releases the packet, mismatch drops it.
            S_CHECK: begin
               if (accept) begin
                  if (byte_i == chk_q) begin
                     state_q        <= S_OUT;
                     byte_ready_o   <= 1'b0;
                     packet_valid_o <= 1'b1;
                  end else begin
                     state_q   <= S_IDLE;
                     error_o   <= 1'b1;
                     payload_q <= '0;
                     len_q     <= '0;
                  end
               end
            end
`endif

            S_OUT: begin
               if (packet_ready_i) begin
                  state_q        <= S_IDLE;
                  byte_ready_o   <= 1'b1;
                  packet_valid_o <= 1'b0;
               end
            end

            default: begin
               state_q        <= S_IDLE;
               byte_ready_o   <= 1'b1;
               packet_valid_o <= 1'b0;
            end
         endcase
      end
   end

   assign packet_payload_o = payload_q;
   assign payload_length_o = len_q;

   // Field decode straight from the held payload; mismatched formats read 0.
   logic [1:0]      fmt;
   int unsigned     sign_pos;
   logic            sign_bit;
   logic [XLEN-1:0] addr_ext;

   assign fmt = payload_q[1:0];

   always_comb begin
      sign_pos = 32'(len_q) * 32'd8 - 32'd1;
      sign_bit = 1'b0;
      addr_ext = '0;
      if (len_q != '0) begin
         sign_bit = payload_q[IDX_W'(sign_pos)];
      end
      // Bits above the last received payload bit replicate its MSB.
      for (int unsigned i = 0; i < XLEN; i++) begin
         addr_ext[i] = ((i + 32'd2) > sign_pos) ? sign_bit : payload_q[IDX_W'(i + 32'd2)];
      end
   end

   always_comb begin
      format_o     = fmt;
      subformat_o  = '0;
      branches_o   = '0;
      branch_map_o = '0;
      address_o    = '0;
      if (fmt == 2'd3) begin
         subformat_o = payload_q[3:2];
      end
      if (fmt == 2'd1) begin
         branches_o   = payload_q[2 +: BRANCH_COUNT_LEN];
         branch_map_o = payload_q[2 + BRANCH_COUNT_LEN +: BRANCH_MAP_LEN];
      end
      if (fmt == 2'd2) begin
         address_o = addr_ext;
      end
   end

endmodule

// File: tb/tb_trdb_packet_parser.sv
// Directed bench for trdb_packet_parser: inputs driven on the falling edge,
// outputs checked on the falling edge against hand-computed values.
module tb_trdb_packet_parser;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         byte_valid_i = 1'b0;
   logic [7:0]   byte_i = 8'h00;
   logic         byte_ready_o;
   logic         packet_valid_o;
   logic         packet_ready_i = 1'b0;
   logic [255:0] packet_payload_o;
   logic [5:0]   payload_length_o;
   logic [1:0]   format_o;
   logic [1:0]   subformat_o;
   logic [4:0]   branches_o;
   logic [30:0]  branch_map_o;
   logic [31:0]  address_o;
   logic         error_o;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [7:0]  acc;

   always #5 clk_i = ~clk_i;

   trdb_packet_parser dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .byte_valid_i     (byte_valid_i),
      .byte_i           (byte_i),
      .byte_ready_o     (byte_ready_o),
      .packet_valid_o   (packet_valid_o),
      .packet_ready_i   (packet_ready_i),
      .packet_payload_o (packet_payload_o),
      .payload_length_o (payload_length_o),
      .format_o         (format_o),
      .subformat_o      (subformat_o),
      .branches_o       (branches_o),
      .branch_map_o     (branch_map_o),
      .address_o        (address_o),
      .error_o          (error_o)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one byte and hold it until it is taken; returns on the falling
   // edge right after the accepting rising edge.
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      byte_valid_i = 1'b1;
      byte_i       = b;
      while (!byte_ready_o && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk("accept_wait", 256'(byte_ready_o), 256'(1));
      @(negedge clk_i);
      byte_valid_i = 1'b0;
      acc = acc ^ b;
   endtask

   task automatic start_pkt(input logic [7:0] hdr);
      acc = 8'h00;
      send_byte(hdr);
   endtask

   // Appends the checksum byte when the parser expects one.
   task automatic end_pkt();
`ifdef TRDB_PARSER_CHECKSUM_EN
      send_byte(acc);
`endif
   endtask

   task automatic consume();
      packet_ready_i = 1'b1;
      @(negedge clk_i);
      packet_ready_i = 1'b0;
      chk("consume_valid", 256'(packet_valid_o), 256'(0));
      chk("consume_ready", 256'(byte_ready_o), 256'(1));
   endtask

   initial begin
      acc = 8'h00;
      repeat (2) @(negedge clk_i);
      chk("rst_ready",   256'(byte_ready_o), 256'(1));
      chk("rst_valid",   256'(packet_valid_o), 256'(0));
      chk("rst_error",   256'(error_o), 256'(0));
      chk("rst_payload", packet_payload_o, 256'(0));
      chk("rst_len",     256'(payload_length_o), 256'(0));
      chk("rst_addr",    256'(address_o), 256'(0));
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Format 2 packet, short address.
      start_pkt(8'h02); send_byte(8'h12); send_byte(8'h34); end_pkt();
      chk("a_valid",   256'(packet_valid_o), 256'(1));
      chk("a_payload", packet_payload_o, 256'h3412);
      chk("a_len",     256'(payload_length_o), 256'(2));
      chk("a_format",  256'(format_o), 256'(2));
      chk("a_addr",    256'(address_o), 256'h0000_0D04);
      chk("a_branch",  256'(branches_o), 256'(0));

      // Backpressure with a header pending: nothing moves for 5 cycles.
      byte_valid_i = 1'b1;
      byte_i       = 8'h01;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("bp_ready",   256'(byte_ready_o), 256'(0));
         chk("bp_valid",   256'(packet_valid_o), 256'(1));
         chk("bp_payload", packet_payload_o, 256'h3412);
      end
      packet_ready_i = 1'b1;
      @(negedge clk_i);
      packet_ready_i = 1'b0;
      chk("bp_hs_valid", 256'(packet_valid_o), 256'(0));
      chk("bp_hs_ready", 256'(byte_ready_o), 256'(1));
      // Header taken on the very next edge, payload byte on the one after.
      @(negedge clk_i);
      byte_i = 8'h07;
      @(negedge clk_i);
      byte_valid_i = 1'b0;
`ifdef TRDB_PARSER_CHECKSUM_EN
      acc = 8'h01 ^ 8'h07;
      end_pkt();
`endif
      chk("d_valid",  256'(packet_valid_o), 256'(1));
      chk("d_payload", packet_payload_o, 256'h07);
      chk("d_format", 256'(format_o), 256'(3));
      chk("d_subfmt", 256'(subformat_o), 256'(1));
      consume();

      // Format 2 with a negative address, idle gaps between bytes.
      start_pkt(8'h02);
      repeat (3) @(negedge clk_i);
      send_byte(8'h02);
      repeat (2) @(negedge clk_i);
      chk("b_gap_valid", 256'(packet_valid_o), 256'(0));
      send_byte(8'h80); end_pkt();
      chk("b_valid",   256'(packet_valid_o), 256'(1));
      chk("b_payload", packet_payload_o, 256'h8002);
      chk("b_addr",    256'(address_o), 256'hFFFF_E000);
      consume();

      // Format 1 branch packet.
      start_pkt(8'h05);
      send_byte(8'h45); send_byte(8'h23); send_byte(8'h01);
      send_byte(8'h00); send_byte(8'h00); end_pkt();
      chk("c_valid",  256'(packet_valid_o), 256'(1));
      chk("c_len",    256'(payload_length_o), 256'(5));
      chk("c_format", 256'(format_o), 256'(1));
      chk("c_branch", 256'(branches_o), 256'h11);
      chk("c_map",    256'(branch_map_o), 256'h246);
      chk("c_addr",   256'(address_o), 256'(0));
      chk("c_subfmt", 256'(subformat_o), 256'(0));
      consume();

      // Bad headers: zero length and one beyond the maximum.
      send_byte(8'h00);
      chk("e0_error", 256'(error_o), 256'(1));
      chk("e0_valid", 256'(packet_valid_o), 256'(0));
      chk("e0_ready", 256'(byte_ready_o), 256'(1));
      @(negedge clk_i);
      chk("e0_pulse", 256'(error_o), 256'(0));
      send_byte(8'h21);
      chk("e1_error", 256'(error_o), 256'(1));
      @(negedge clk_i);
      chk("e1_pulse", 256'(error_o), 256'(0));
      chk("e1_valid", 256'(packet_valid_o), 256'(0));

      // Header bits [7:6] ignored.
      start_pkt(8'hC1); send_byte(8'h0A); end_pkt();
      chk("h_valid", 256'(packet_valid_o), 256'(1));
      chk("h_len",   256'(payload_length_o), 256'(1));
      chk("h_error", 256'(error_o), 256'(0));
      consume();

      // Maximum-length packet, bytes 1..32.
      start_pkt(8'h20);
      for (int i = 0; i < 32; i++) send_byte(8'(i + 1));
      end_pkt();
      chk("m_valid", 256'(packet_valid_o), 256'(1));
      chk("m_len",   256'(payload_length_o), 256'(32));
      chk("m_lo",    256'(packet_payload_o[7:0]), 256'h01);
      chk("m_hi",    256'(packet_payload_o[255:248]), 256'h20);
      chk("m_map",   256'(branch_map_o), 256'h0A08_0604);
      consume();

      // Reset mid-packet drops the partial packet.
      start_pkt(8'h03); send_byte(8'hAA);
      rst_ni = 1'b0;
      #1;
      chk("r_ready",   256'(byte_ready_o), 256'(1));
      chk("r_payload", packet_payload_o, 256'(0));
      chk("r_len",     256'(payload_length_o), 256'(0));
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      start_pkt(8'h01); send_byte(8'h06); end_pkt();
      chk("r_valid",   256'(packet_valid_o), 256'(1));
      chk("r_payload2", packet_payload_o, 256'h06);
      chk("r_addr",    256'(address_o), 256'h1);
      consume();

`ifdef TRDB_PARSER_CHECKSUM_EN
      start_pkt(8'h01); send_byte(8'h03); send_byte(8'h02);
      chk("k_valid", 256'(packet_valid_o), 256'(1));
      chk("k_error", 256'(error_o), 256'(0));
      consume();
      start_pkt(8'h01); send_byte(8'h03); send_byte(8'h00);
      chk("k_bad_error", 256'(error_o), 256'(1));
      chk("k_bad_valid", 256'(packet_valid_o), 256'(0));
      repeat (3) @(negedge clk_i);
      chk("k_bad_later", 256'(packet_valid_o), 256'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
